// File: rtl/hazard_ctrl_pkg.sv
// hazard_pkg: shared encodings for the pipeline hazard controller and its
// forwarding units (FSM states, forwarding selects, writeback source codes).
package hazard_pkg;

    // FSM state encoding
    localparam logic [0:0] RUN      = 1'b0;
    localparam logic [0:0] MDU_WAIT = 1'b1;

    // ALU operand forwarding select
    typedef logic [1:0] fwd_sel_t;
    localparam fwd_sel_t FWD_GPR = 2'b00;
    localparam fwd_sel_t FWD_MEM = 2'b01;
    localparam fwd_sel_t FWD_WB  = 2'b10;

    // memtoreg code that marks the EXE instruction as a load
    localparam logic [1:0] MEMTORG_LOAD = 2'b10;

    // $zero register index; it never produces a forward or a stall
    localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: datapath <-> hazard controller signal bundle.
// master = datapath side, slave = hazard controller side.
interface hazard_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
);
    logic [REG_W-1:0] rs_id;
    logic [REG_W-1:0] rt_id;
    logic [REG_W-1:0] rs_exe;
    logic [REG_W-1:0] rt_exe;
    logic [REG_W-1:0] rw_exe;
    logic [REG_W-1:0] rw_mem;
    logic [REG_W-1:0] rw_wb;
    logic             reg_write_exe;
    logic             reg_write_mem;
    logic             reg_write_wb;
    logic [1:0]       memtoreg_exe;
    logic             jump_id;
    logic             branch_taken_exe;
    logic             mdu_start_exe;
    logic             mdu_done;

    logic             pc_en;
    logic             if_id_en;
    logic             id_exe_en;
    logic             if_id_flush;
    logic             id_exe_flush;
    logic             exe_mem_flush;
    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output rs_id, rt_id, rs_exe, rt_exe, rw_exe, rw_mem, rw_wb,
               reg_write_exe, reg_write_mem, reg_write_wb, memtoreg_exe,
               jump_id, branch_taken_exe, mdu_start_exe, mdu_done,
        input  pc_en, if_id_en, id_exe_en, if_id_flush, id_exe_flush,
               exe_mem_flush, fwd_a_sel, fwd_b_sel, stall_cycles, flush_count
    );

    modport slave (
        input  rs_id, rt_id, rs_exe, rt_exe, rw_exe, rw_mem, rw_wb,
               reg_write_exe, reg_write_mem, reg_write_wb, memtoreg_exe,
               jump_id, branch_taken_exe, mdu_start_exe, mdu_done,
        output pc_en, if_id_en, id_exe_en, if_id_flush, id_exe_flush,
               exe_mem_flush, fwd_a_sel, fwd_b_sel, stall_cycles, flush_count
    );

endinterface

// File: rtl/hazard_ctrl_fwd_unit.sv
// fwd_unit: combinational operand forwarding select for one ALU source.
// The younger result (MEM) wins over the older one (WB); $zero never forwards.
module fwd_unit
    import hazard_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] src,
    input  logic [REG_W-1:0] rw_mem,
    input  logic             reg_write_mem,
    input  logic [REG_W-1:0] rw_wb,
    input  logic             reg_write_wb,
    output fwd_sel_t         sel
);

    // Pick the most recent in-flight producer of src, else the register file
    always_comb begin
        sel = FWD_GPR;
        if (reg_write_mem && (rw_mem != REG_W'(REG_ZERO)) && (rw_mem == src)) begin
            sel = FWD_MEM;
        end else if (reg_write_wb && (rw_wb != REG_W'(REG_ZERO)) && (rw_wb == src)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forwarding control for the 5-stage MIPS pipeline.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   RUN      | normal flow; load-use, branch and jump hazards resolved
//   MDU_WAIT | multiply/divide in flight; front end frozen, MEM bubbled
//
// Optional build macro: HAZARD_CTRL_PERF_EN adds the stall/flush
// performance counters; without it both counter ports read zero.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
) (
    input  logic         clock,
    input  logic         reset,
    hazard_ctrl_if.slave hif
);

    logic [0:0] state;
    logic [0:0] state_nxt;
    fwd_sel_t   fwd_a_raw;
    fwd_sel_t   fwd_b_raw;
    logic       load_use;
    logic       mdu_hold;

    logic       pc_en;
    logic       if_id_en;
    logic       id_exe_en;
    logic       if_id_flush;
    logic       id_exe_flush;
    logic       exe_mem_flush;
    fwd_sel_t   fwd_a_sel;
    fwd_sel_t   fwd_b_sel;

    fwd_unit #(.REG_W(REG_W)) u_fwd_a (
        .src           (hif.rs_exe),
        .rw_mem        (hif.rw_mem),
        .reg_write_mem (hif.reg_write_mem),
        .rw_wb         (hif.rw_wb),
        .reg_write_wb  (hif.reg_write_wb),
        .sel           (fwd_a_raw)
    );

    fwd_unit #(.REG_W(REG_W)) u_fwd_b (
        .src           (hif.rt_exe),
        .rw_mem        (hif.rw_mem),
        .reg_write_mem (hif.reg_write_mem),
        .rw_wb         (hif.rw_wb),
        .reg_write_wb  (hif.reg_write_wb),
        .sel           (fwd_b_raw)
    );

    assign load_use = (hif.memtoreg_exe == MEMTORG_LOAD) && hif.reg_write_exe &&
                      (hif.rw_exe != REG_W'(REG_ZERO)) &&
                      ((hif.rw_exe == hif.rs_id) || (hif.rw_exe == hif.rt_id));

    // The start cycle already shows the wait pattern so the MDU op stays in EXE;
    // a taken branch in the same cycle kills the start.
    assign mdu_hold = (state == MDU_WAIT) ||
                      (hif.mdu_start_exe && !hif.branch_taken_exe);

    // Next-state logic; mdu_done outside MDU_WAIT is ignored
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:      if (hif.mdu_start_exe && !hif.branch_taken_exe) state_nxt = MDU_WAIT;
            MDU_WAIT: if (hif.mdu_done) state_nxt = RUN;
            default:  state_nxt = RUN;
        endcase
    end

    // State register; reset abandons any MDU wait
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Enables/flushes/selects in priority order: reset, MDU, branch, load-use, jump
    always_comb begin
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        id_exe_en     = 1'b1;
        if_id_flush   = 1'b0;
        id_exe_flush  = 1'b0;
        exe_mem_flush = 1'b0;
        fwd_a_sel     = fwd_a_raw;
        fwd_b_sel     = fwd_b_raw;
        if (reset) begin
            if_id_flush   = 1'b1;
            id_exe_flush  = 1'b1;
            exe_mem_flush = 1'b1;
            fwd_a_sel     = FWD_GPR;
            fwd_b_sel     = FWD_GPR;
        end else if (mdu_hold) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_exe_en     = 1'b0;
            exe_mem_flush = 1'b1;
        end else if (hif.branch_taken_exe) begin
            if_id_flush   = 1'b1;
            id_exe_flush  = 1'b1;
        end else if (load_use) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_exe_flush  = 1'b1;
        end else if (hif.jump_id) begin
            if_id_flush   = 1'b1;
        end
    end

    assign hif.pc_en         = pc_en;
    assign hif.if_id_en      = if_id_en;
    assign hif.id_exe_en     = id_exe_en;
    assign hif.if_id_flush   = if_id_flush;
    assign hif.id_exe_flush  = id_exe_flush;
    assign hif.exe_mem_flush = exe_mem_flush;
    assign hif.fwd_a_sel     = fwd_a_sel;
    assign hif.fwd_b_sel     = fwd_b_sel;

`ifdef HAZARD_CTRL_PERF_EN
    logic             any_flush;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    assign any_flush = if_id_flush || id_exe_flush || exe_mem_flush;

    // Free-running wrap-around counters of stalled and flushing cycles
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_en) stall_q <= stall_q + CNT_W'(1);
            if (any_flush) flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign hif.stall_cycles = stall_q;
    assign hif.flush_count  = flush_q;
`else
    assign hif.stall_cycles = {CNT_W{1'b0}};
    assign hif.flush_count  = {CNT_W{1'b0}};
`endif

endmodule
